cfa_frame_store: RTL and testbench

Frame-memory responder on the far side of the CFA demosaic datapath. It accepts a raw Bayer frame from a pixel stream and stores it in four 12-bit planes (raw, green, red, blue), pre-seeding each pixel's native colour plane. It then starts the CFA engine and serves the engine's read port and per-channel write port until the engine reports completion. Finally it streams the reconstructed RGB frame out in row-major order.

---
 rtl/cfa_frame_store.sv | 210 +++++++++++++++++++++
 tb/tb_cfa_frame_store.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfa_frame_store.sv
// rtl/cfa_frame_store.sv - Bayer frame store serving a CFA demosaic engine
// Loads a raw frame into raw/G/R/B planes, serves the engine, then streams RGB out.
module cfa_frame_store #(
    parameter int addressBitWidth = 17,
    parameter int rowBitWidth     = 11,
    parameter int colBitWidth     = 11,
    parameter int dataBitWidth    = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [rowBitWidth-1:0]       rowMax,
    input  logic [colBitWidth-1:0]       colMax,
    input  logic [1:0]                   patternSelect,
    input  logic                         go,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [dataBitWidth-1:0]      in_data,
    output logic                         cfaStart,
    input  logic                         cfaDone,
    input  logic [addressBitWidth-1:0]   readAddress,
    output logic [dataBitWidth-1:0]      raw,
    output logic [dataBitWidth-1:0]      greenRead,
    output logic [dataBitWidth-1:0]      redRead,
    output logic [dataBitWidth-1:0]      blueRead,
    input  logic [addressBitWidth-1:0]   writeAddress,
    input  logic [2:0]                   writeEnable,
    input  logic [dataBitWidth-1:0]      greenWrite,
    input  logic [dataBitWidth-1:0]      redWrite,
    input  logic [dataBitWidth-1:0]      blueWrite,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [3*dataBitWidth-1:0]    out_data,
    output logic                         busy
);
    localparam int AW    = addressBitWidth;
    localparam int DW    = dataBitWidth;
    localparam int PW    = rowBitWidth + colBitWidth + 2;
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    typedef enum logic [2:0] {IDLE, LOAD, START, PROCESS, UNLOAD} state_t;
    state_t state, state_next;

    logic [DW-1:0] raw_mem   [0:DEPTH-1];
    logic [DW-1:0] green_mem [0:DEPTH-1];
    logic [DW-1:0] red_mem   [0:DEPTH-1];
    logic [DW-1:0] blue_mem  [0:DEPTH-1];

    logic [AW-1:0]          cnt;
    logic [AW-1:0]          last;
    logic [rowBitWidth-1:0] row;
    logic [colBitWidth-1:0] col;
    logic [colBitWidth-1:0] col_max;
    logic [1:0]             pat;
    logic                   fetched_last;

    logic          load_beat;
    logic          fetch;
    logic          unload_end;
    logic [1:0]    native;
    logic [1:0]    phase;
    logic [AW-1:0] wr_addr;
    logic          g_we, r_we, b_we;
    logic [DW-1:0] g_wd, r_wd, b_wd;

    assign in_ready  = (state == LOAD);
    assign cfaStart  = (state == START);
    assign busy      = (state != IDLE);
    assign load_beat = (state == LOAD) && in_valid;
    // The output register refills whenever it is empty or being drained this cycle.
    assign fetch      = (state == UNLOAD) && !fetched_last && (!out_valid || out_ready);
    assign unload_end = (state == UNLOAD) && fetched_last && out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = LOAD;
            LOAD:    if (load_beat && cnt == last) state_next = START;
            START:   state_next = PROCESS;
            PROCESS: if (cfaDone) state_next = UNLOAD;
            UNLOAD:  if (unload_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Native colour of the current pixel from its row/column parity and the Bayer layout.
    always_comb begin
        phase = {row[0], col[0]};
        case (pat)
            2'd0:    native = (phase == 2'd0) ? CH_R : (phase == 2'd3) ? CH_B : CH_G;
            2'd1:    native = (phase == 2'd1) ? CH_R : (phase == 2'd2) ? CH_B : CH_G;
            2'd2:    native = (phase == 2'd2) ? CH_R : (phase == 2'd1) ? CH_B : CH_G;
            default: native = (phase == 2'd3) ? CH_R : (phase == 2'd0) ? CH_B : CH_G;
        endcase
    end

    always_comb begin
        wr_addr = cnt;
        g_we = 1'b0;
        r_we = 1'b0;
        b_we = 1'b0;
        g_wd = '0;
        r_wd = '0;
        b_wd = '0;
        if (state == LOAD) begin
            g_we = in_valid;
            r_we = in_valid;
            b_we = in_valid;
            g_wd = (native == CH_G) ? in_data : '0;
            r_wd = (native == CH_R) ? in_data : '0;
            b_wd = (native == CH_B) ? in_data : '0;
        end else if (state == PROCESS) begin
            wr_addr = writeAddress;
            g_we = writeEnable[2];
            r_we = writeEnable[1];
            b_we = writeEnable[0];
            g_wd = greenWrite;
            r_wd = redWrite;
            b_wd = blueWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (load_beat) raw_mem[cnt] <= in_data;
        if (g_we) green_mem[wr_addr] <= g_wd;
        if (r_we) red_mem[wr_addr] <= r_wd;
        if (b_we) blue_mem[wr_addr] <= b_wd;
    end

    // Registered read port; a same-cycle write is not visible until the next read.
    always_ff @(posedge clk) begin
        if (rst) begin
            raw       <= '0;
            greenRead <= '0;
            redRead   <= '0;
            blueRead  <= '0;
        end else begin
            raw       <= raw_mem[readAddress];
            greenRead <= green_mem[readAddress];
            redRead   <= red_mem[readAddress];
            blueRead  <= blue_mem[readAddress];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            last         <= '0;
            row          <= '0;
            col          <= '0;
            col_max      <= '0;
            pat          <= '0;
            fetched_last <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        col_max <= colMax;
                        pat     <= patternSelect;
                        last    <= AW'((PW'(rowMax) + PW'(1)) * (PW'(colMax) + PW'(1)) - PW'(1));
                        cnt     <= '0;
                        row     <= '0;
                        col     <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        cnt <= cnt + AW'(1);
                        if (col == col_max) begin
                            col <= '0;
                            row <= row + rowBitWidth'(1);
                        end else begin
                            col <= col + colBitWidth'(1);
                        end
                    end
                end
                PROCESS: begin
                    if (cfaDone) begin
                        cnt          <= '0;
                        fetched_last <= 1'b0;
                    end
                end
                UNLOAD: begin
                    if (fetch) begin
                        out_data  <= {green_mem[cnt], red_mem[cnt], blue_mem[cnt]};
                        out_valid <= 1'b1;
                        cnt       <= cnt + AW'(1);
                        if (cnt == last) fetched_last <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cfa_frame_store.sv
// tb/tb_cfa_frame_store.sv - self-checking bench for cfa_frame_store
// Scenario tasks against a plane-array reference model built from the Bayer pattern strings.
module tb_cfa_frame_store;
    localparam int AW = 17;
    localparam int RW = 11;
    localparam int CW = 11;
    localparam int DW = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [RW-1:0]   rowMax = '0;
    logic [CW-1:0]   colMax = '0;
    logic [1:0]      patternSelect = '0;
    logic            go = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_data = '0;
    logic            cfaStart;
    logic            cfaDone = 1'b0;
    logic [AW-1:0]   readAddress = '0;
    logic [DW-1:0]   raw, greenRead, redRead, blueRead;
    logic [AW-1:0]   writeAddress = '0;
    logic [2:0]      writeEnable = '0;
    logic [DW-1:0]   greenWrite = '0, redWrite = '0, blueWrite = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [3*DW-1:0] out_data;
    logic            busy;

    cfa_frame_store dut (
        .clk(clk), .rst(rst), .rowMax(rowMax), .colMax(colMax), .patternSelect(patternSelect),
        .go(go), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfaStart(cfaStart), .cfaDone(cfaDone), .readAddress(readAddress),
        .raw(raw), .greenRead(greenRead), .redRead(redRead), .blueRead(blueRead),
        .writeAddress(writeAddress), .writeEnable(writeEnable),
        .greenWrite(greenWrite), .redWrite(redWrite), .blueWrite(blueWrite),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int start_count = 0;
    always @(posedge clk) if (cfaStart) start_count <= start_count + 1;

    int frame_data [256];
    int m_raw [256];
    int m_g [256];
    int m_r [256];
    int m_b [256];
    string pats [4];
    logic [3*DW-1:0] got [$];

    function automatic void model_load(input int n, input int cols, input int p);
        for (int a = 0; a < n; a++) begin
            byte ch;
            ch = pats[p][(a / cols) % 2 * 2 + (a % cols) % 2];
            m_raw[a] = frame_data[a];
            m_g[a] = (ch == "G") ? frame_data[a] : 0;
            m_r[a] = (ch == "R") ? frame_data[a] : 0;
            m_b[a] = (ch == "B") ? frame_data[a] : 0;
        end
    endfunction

    function automatic logic [3*DW-1:0] model_beat(input int a);
        return {DW'(m_g[a]), DW'(m_r[a]), DW'(m_b[a])};
    endfunction

    task automatic start_frame(input int rows, input int cols, input int p);
        rowMax = RW'(rows - 1);
        colMax = CW'(cols - 1);
        patternSelect = 2'(p);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic load_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            if ($urandom_range(3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data = DW'(frame_data[i]);
            guard = 0;
            while (!in_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            n_cmp++;
            if (guard >= 20) begin
                n_bad++;
                $display("FAIL load_stall: in_ready=%0b want 1 at pixel %0d", in_ready, i);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic read_addr(input int a, output int rv, output int gv, output int rdv, output int bv);
        readAddress = AW'(a);
        @(negedge clk);
        rv = int'(raw);
        gv = int'(greenRead);
        rdv = int'(redRead);
        bv = int'(blueRead);
    endtask

    task automatic pulse_done();
        cfaDone = 1'b1;
        @(negedge clk);
        cfaDone = 1'b0;
    endtask

    task automatic collect(input int n, input int pct);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 2000) begin
            out_ready = ($urandom_range(99) < pct);
            if (out_ready && out_valid) begin
                got.push_back(out_data);
                k++;
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        n_cmp++;
        if (k != n) begin
            n_bad++;
            $display("FAIL unload_timeout: got %0d beats want %0d", k, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp += 9;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        if (cfaStart !== 1'b0) begin n_bad++; $display("FAIL rst_cfaStart: got %0b want 0", cfaStart); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data: got %0h want 0", out_data); end
        if (raw !== '0) begin n_bad++; $display("FAIL rst_raw: got %0h want 0", raw); end
        if (greenRead !== '0) begin n_bad++; $display("FAIL rst_green: got %0h want 0", greenRead); end
        if (redRead !== '0) begin n_bad++; $display("FAIL rst_red: got %0h want 0", redRead); end
        if (blueRead !== '0) begin n_bad++; $display("FAIL rst_blue: got %0h want 0", blueRead); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rggb_4x4();
        int rv, gv, rdv, bv;
        int order [16];
        for (int i = 0; i < 16; i++) begin frame_data[i] = i; order[i] = i; end
        order.shuffle();
        start_frame(4, 4, 0);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL go_to_ready: got %0b want 1", in_ready); end
        load_pixels(16);
        model_load(16, 4, 0);
        n_cmp++;
        if (cfaStart !== 1'b1) begin n_bad++; $display("FAIL start_pulse: got %0b want 1", cfaStart); end
        @(negedge clk);
        n_cmp++;
        if (cfaStart !== 1'b0) begin n_bad++; $display("FAIL start_width: got %0b want 0", cfaStart); end
        for (int i = 0; i < 16; i++) begin
            int a = order[i];
            read_addr(a, rv, gv, rdv, bv);
            n_cmp += 4;
            if (rv != m_raw[a]) begin n_bad++; $display("FAIL rggb_raw[%0d]: got %0d want %0d", a, rv, m_raw[a]); end
            if (gv != m_g[a]) begin n_bad++; $display("FAIL rggb_green[%0d]: got %0d want %0d", a, gv, m_g[a]); end
            if (rdv != m_r[a]) begin n_bad++; $display("FAIL rggb_red[%0d]: got %0d want %0d", a, rdv, m_r[a]); end
            if (bv != m_b[a]) begin n_bad++; $display("FAIL rggb_blue[%0d]: got %0d want %0d", a, bv, m_b[a]); end
        end
        pulse_done();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL unload_early: out_valid=%0b want 0", out_valid); end
        @(negedge clk);
        n_cmp += 2;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL unload_latency: out_valid=%0b want 1", out_valid); end
        if (out_data !== model_beat(0)) begin n_bad++; $display("FAIL unload_first: got %0h want %0h", out_data, model_beat(0)); end
        got.delete();
        collect(16, 70);
        for (int a = 0; a < 16 && a < got.size(); a++) begin
            n_cmp++;
            if (got[a] !== model_beat(a)) begin n_bad++; $display("FAIL rggb_beat[%0d]: got %0h want %0h", a, got[a], model_beat(a)); end
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rggb_end_idle: busy=%0b want 0", busy); end
    endtask

    task automatic test_bggr_gating();
        int rv, gv, rdv, bv;
        in_valid = 1'b1;
        in_data = 12'hFFF;
        repeat (3) begin
            @(negedge clk);
            n_cmp += 2;
            if (in_ready !== 1'b0) begin n_bad++; $display("FAIL idle_in_ready: got %0b want 0", in_ready); end
            if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %0b want 0", busy); end
        end
        in_valid = 1'b0;
        frame_data[0] = 10; frame_data[1] = 20; frame_data[2] = 30; frame_data[3] = 40;
        start_frame(2, 2, 3);
        cfaDone = 1'b1;
        writeEnable = 3'b111;
        writeAddress = AW'(4);
        greenWrite = 12'h777; redWrite = 12'h777; blueWrite = 12'h777;
        @(negedge clk);
        cfaDone = 1'b0;
        writeEnable = 3'b000;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL done_in_load: in_ready=%0b want 1", in_ready); end
        load_pixels(4);
        model_load(4, 2, 3);
        @(negedge clk);
        rowMax = RW'(7);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        n_cmp += 2;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL go_in_process_busy: got %0b want 1", busy); end
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL go_in_process_ready: got %0b want 0", in_ready); end
        for (int a = 0; a < 5; a++) begin
            read_addr(a, rv, gv, rdv, bv);
            n_cmp += 4;
            if (rv != m_raw[a]) begin n_bad++; $display("FAIL bggr_raw[%0d]: got %0d want %0d", a, rv, m_raw[a]); end
            if (gv != m_g[a]) begin n_bad++; $display("FAIL bggr_green[%0d]: got %0d want %0d", a, gv, m_g[a]); end
            if (rdv != m_r[a]) begin n_bad++; $display("FAIL bggr_red[%0d]: got %0d want %0d", a, rdv, m_r[a]); end
            if (bv != m_b[a]) begin n_bad++; $display("FAIL bggr_blue[%0d]: got %0d want %0d", a, bv, m_b[a]); end
        end
        pulse_done();
        got.delete();
        collect(4, 100);
        for (int a = 0; a < 4 && a < got.size(); a++) begin
            n_cmp++;
            if (got[a] !== model_beat(a)) begin n_bad++; $display("FAIL bggr_beat[%0d]: got %0h want %0h", a, got[a], model_beat(a)); end
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL bggr_end_idle: busy=%0b want 0", busy); end
    endtask

    task automatic test_collision_random(input int rows, input int cols, input int p, input int nwr, input bit hit6);
        int n = rows * cols;
        for (int i = 0; i < n; i++) frame_data[i] = int'($urandom_range(4095));
        start_frame(rows, cols, p);
        load_pixels(n);
        model_load(n, cols, p);
        @(negedge clk);
        if (hit6) begin
            readAddress = AW'(6); writeAddress = AW'(6);
            writeEnable = 3'b100; greenWrite = 12'hABC;
            redWrite = 12'h111; blueWrite = 12'h222;
            @(negedge clk);
            writeEnable = 3'b000;
            n_cmp++;
            if (greenRead != DW'(m_g[6])) begin n_bad++; $display("FAIL collide_old: got %0h want %0h", greenRead, m_g[6]); end
            m_g[6] = 'hABC;
            @(negedge clk);
            n_cmp += 3;
            if (greenRead !== 12'hABC) begin n_bad++; $display("FAIL collide_new: got %0h want abc", greenRead); end
            if (redRead != DW'(m_r[6])) begin n_bad++; $display("FAIL collide_red: got %0h want %0h", redRead, m_r[6]); end
            if (blueRead != DW'(m_b[6])) begin n_bad++; $display("FAIL collide_blue: got %0h want %0h", blueRead, m_b[6]); end
        end
        for (int i = 0; i < nwr; i++) begin
            int ra = int'($urandom_range(n - 1));
            int wa = int'($urandom_range(n - 1));
            logic [2:0] we = 3'($urandom_range(7));
            readAddress = AW'(ra); writeAddress = AW'(wa); writeEnable = we;
            greenWrite = DW'($urandom); redWrite = DW'($urandom); blueWrite = DW'($urandom);
            @(negedge clk);
            n_cmp += 4;
            if (raw != DW'(m_raw[ra])) begin n_bad++; $display("FAIL rw_raw[%0d]: got %0h want %0h", ra, raw, m_raw[ra]); end
            if (greenRead != DW'(m_g[ra])) begin n_bad++; $display("FAIL rw_green[%0d]: got %0h want %0h", ra, greenRead, m_g[ra]); end
            if (redRead != DW'(m_r[ra])) begin n_bad++; $display("FAIL rw_red[%0d]: got %0h want %0h", ra, redRead, m_r[ra]); end
            if (blueRead != DW'(m_b[ra])) begin n_bad++; $display("FAIL rw_blue[%0d]: got %0h want %0h", ra, blueRead, m_b[ra]); end
            if (we[2]) m_g[wa] = int'(greenWrite);
            if (we[1]) m_r[wa] = int'(redWrite);
            if (we[0]) m_b[wa] = int'(blueWrite);
        end
        writeEnable = 3'b000;
        pulse_done();
        got.delete();
        collect(n, 60);
        for (int a = 0; a < n && a < got.size(); a++) begin
            n_cmp++;
            if (got[a] !== model_beat(a)) begin n_bad++; $display("FAIL rand_beat[%0d]: got %0h want %0h", a, got[a], model_beat(a)); end
        end
    endtask

    task automatic test_backpressure();
        logic [3*DW-1:0] held;
        for (int i = 0; i < 16; i++) frame_data[i] = int'($urandom_range(4095));
        start_frame(4, 4, 1);
        load_pixels(16);
        model_load(16, 4, 1);
        @(negedge clk);
        pulse_done();
        got.delete();
        collect(6, 100);
        held = out_data;
        repeat (5) begin
            @(negedge clk);
            n_cmp += 2;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %0b want 1", out_valid); end
            if (out_data !== held) begin n_bad++; $display("FAIL bp_stable: got %0h want %0h", out_data, held); end
        end
        collect(10, 100);
        n_cmp++;
        if (got.size() != 16) begin n_bad++; $display("FAIL bp_count: got %0d want 16", got.size()); end
        for (int a = 0; a < 16 && a < got.size(); a++) begin
            n_cmp++;
            if (got[a] !== model_beat(a)) begin n_bad++; $display("FAIL bp_beat[%0d]: got %0h want %0h", a, got[a], model_beat(a)); end
        end
    endtask

    task automatic test_reset_in_load();
        int s0;
        for (int i = 0; i < 16; i++) frame_data[i] = int'($urandom_range(4095));
        s0 = start_count;
        start_frame(4, 4, 2);
        load_pixels(7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp += 2;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_load_busy: got %0b want 0", busy); end
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_load_ready: got %0b want 0", in_ready); end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (start_count != s0) begin n_bad++; $display("FAIL rst_no_start: got %0d pulses want 0", start_count - s0); end
        start_frame(4, 4, 2);
        load_pixels(16);
        model_load(16, 4, 2);
        @(negedge clk);
        pulse_done();
        got.delete();
        collect(16, 80);
        n_cmp++;
        if (start_count - s0 != 1) begin n_bad++; $display("FAIL rst_one_start: got %0d pulses want 1", start_count - s0); end
        for (int a = 0; a < 16 && a < got.size(); a++) begin
            n_cmp++;
            if (got[a] !== model_beat(a)) begin n_bad++; $display("FAIL rst_beat[%0d]: got %0h want %0h", a, got[a], model_beat(a)); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pats[0] = "RGGB"; pats[1] = "GRBG"; pats[2] = "GBRG"; pats[3] = "BGGR";
        @(negedge clk);
        test_reset();
        test_rggb_4x4();
        test_bggr_gating();
        test_collision_random(4, 4, int'($urandom_range(3)), 10, 1'b1);
        for (int k = 0; k < 4; k++)
            test_collision_random(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), int'($urandom_range(3)), 12, 1'b0);
        test_backpressure();
        test_reset_in_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
